// File: rtl/ro_puf_ctrl.sv
// rtl/ro_puf_ctrl.sv - ring-oscillator PUF race sequencer
// Selects an RO pair per response bit, runs the race and shifts the winner into the response word.
module ro_puf_ctrl #(
    parameter int RESP_BITS = 8,
    parameter int SEL_W     = 4,
    parameter int SETTLE    = 4,
    parameter int TIMEOUT   = 4096,
    parameter int TO_W      = 13
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [RESP_BITS*2*SEL_W-1:0]   challenge,
    input  logic [1:0]                     race_fin,
    output logic [SEL_W-1:0]               sel_a,
    output logic [SEL_W-1:0]               sel_b,
    output logic                           ro_en,
    output logic                           cnt_rst,
    output logic                           busy,
    output logic                           done,
    output logic [RESP_BITS-1:0]           response,
    output logic                           tie,
    output logic                           timeout_err
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [TO_W-1:0]  SETTLE_LAST = TO_W'(SETTLE - 1);
    localparam logic [TO_W-1:0]  RUN_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_CAPTURE,
        S_COOL,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [RESP_BITS*2*SEL_W-1:0]   chal_q, chal_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [TO_W-1:0]                cnt_q, cnt_d;
    logic                           bit_q, bit_d;
    logic [RESP_BITS-1:0]           resp_q, resp_d;
    logic                           tie_q, tie_d;
    logic                           to_q, to_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            chal_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            resp_q  <= '0;
            tie_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            to_q    <= to_d;
        end
    end

    // cnt_q is shared: settle count in SETUP/COOL, timeout count in RUN.
    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        to_d    = to_q;
        ro_en   = 1'b0;
        cnt_rst = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    resp_d  = '0;
                    tie_d   = 1'b0;
                    to_d    = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                busy = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                ro_en   = 1'b1;
                cnt_rst = 1'b0;
                if (race_fin != 2'b00) begin
                    bit_d   = (race_fin == 2'b01);
                    tie_d   = tie_q | (race_fin == 2'b11);
                    state_d = S_CAPTURE;
                end else if (cnt_q == RUN_LAST) begin
                    bit_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_CAPTURE: begin
                busy          = 1'b1;
                resp_d[idx_q] = bit_q;
                cnt_d         = '0;
                state_d       = S_COOL;
            end
            S_COOL: begin
                busy = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel_a       = chal_q[int'(idx_q)*2*SEL_W +: SEL_W];
    assign sel_b       = chal_q[int'(idx_q)*2*SEL_W + SEL_W +: SEL_W];
    assign response    = resp_q;
    assign tie         = tie_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb/tb_ro_puf_ctrl.sv - directed self-checking bench for ro_puf_ctrl
// Instance a uses TIMEOUT=4096, instance b uses TIMEOUT=16; a shared race model drives race_fin.
module tb_ro_puf_ctrl;

    localparam int RB = 8;
    localparam int SW = 4;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [RB*2*SW-1:0] challenge = '0;
    logic [1:0] race_fin = 2'b00;

    logic [SW-1:0] a_sel_a, a_sel_b, b_sel_a, b_sel_b;
    logic a_ro_en, a_cnt_rst, a_busy, a_done, a_tie, a_to;
    logic b_ro_en, b_cnt_rst, b_busy, b_done, b_tie, b_to;
    logic [RB-1:0] a_resp, b_resp;

    always #5 clk = ~clk;

    ro_puf_ctrl #(.RESP_BITS(RB), .SEL_W(SW), .SETTLE(ST), .TIMEOUT(4096), .TO_W(13)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .challenge(challenge), .race_fin(race_fin),
        .sel_a(a_sel_a), .sel_b(a_sel_b), .ro_en(a_ro_en), .cnt_rst(a_cnt_rst), .busy(a_busy),
        .done(a_done), .response(a_resp), .tie(a_tie), .timeout_err(a_to)
    );

    ro_puf_ctrl #(.RESP_BITS(RB), .SEL_W(SW), .SETTLE(ST), .TIMEOUT(16), .TO_W(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .challenge(challenge), .race_fin(race_fin),
        .sel_a(b_sel_a), .sel_b(b_sel_b), .ro_en(b_ro_en), .cnt_rst(b_cnt_rst), .busy(b_busy),
        .done(b_done), .response(b_resp), .tie(b_tie), .timeout_err(b_to)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Race model: plan_dly[i] is the RUN cycle (1-based) on which race i finishes, 0 = never.
    int          plan_dly [RB];
    logic [1:0]  plan_val [RB];
    int          run_len  [RB];
    logic [1:0]  idle_fin = 2'b00;
    int          race_idx = 0;
    int          run_cnt = 0;
    logic [RB*2*SW-1:0] chal_m = '0;

    always @(negedge clk) begin
        if (rst) begin
            race_idx = 0;
            run_cnt  = 0;
            race_fin = 2'b00;
        end else begin
            if ((start_a && !a_busy && !a_done) || (start_b && !b_busy && !b_done)) begin
                race_idx = 0;
                chal_m   = challenge;
            end
            if (a_ro_en || b_ro_en) begin
                if (run_cnt == 0 && race_idx < RB) begin
                    chk("sel_a", a_ro_en ? a_sel_a : b_sel_a, chal_m[race_idx*2*SW +: SW]);
                    chk("sel_b", a_ro_en ? a_sel_b : b_sel_b, chal_m[race_idx*2*SW + SW +: SW]);
                end
                run_cnt++;
                race_fin = (race_idx < RB && plan_dly[race_idx] == run_cnt) ? plan_val[race_idx] : 2'b00;
            end else begin
                if (run_cnt != 0) begin
                    if (race_idx < RB) run_len[race_idx] = run_cnt;
                    race_idx++;
                    run_cnt = 0;
                end
                race_fin = idle_fin;
            end
        end
    end

    task automatic set_plan(input int dly, input logic [1:0] v_even, input logic [1:0] v_odd);
        for (int i = 0; i < RB; i++) begin
            plan_dly[i] = dly;
            plan_val[i] = (i % 2 == 0) ? v_even : v_odd;
            run_len[i]  = 0;
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        int seen;
        seen = 0;
        cycles = 0;
        while (seen == 0 && cycles < budget) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            cycles++;
            if (a_done || b_done) seen = 1;
        end
        if (seen == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int cyc;
    int dones;

    initial begin
        set_plan(0, 2'b00, 2'b00);

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ro_en", a_ro_en, 0);
        chk("rst_cnt_rst", a_cnt_rst, 1);
        chk("rst_resp", a_resp, 0);
        chk("rst_b_cnt_rst", b_cnt_rst, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal: 89-cycle races, A wins on even bits
        set_plan(89, 2'b01, 2'b10);
        challenge = 64'h0123_4567_89AB_CDEF;
        start_a = 1'b1;
        wait_done(2000, cyc);
        chk("nom_latency", cyc, 785);
        chk("nom_resp", a_resp, 8'h55);
        chk("nom_tie", a_tie, 0);
        chk("nom_to", a_to, 0);
        chk("nom_busy_in_done", a_busy, 0);
        chk("nom_run_len", run_len[4], 89);
        @(posedge clk); #1;
        chk("nom_done_once", a_done, 0);
        chk("nom_hold", a_resp, 8'h55);

        // Tie on race 3
        set_plan(5, 2'b01, 2'b01);
        plan_val[3] = 2'b11;
        challenge = 64'hFEDC_BA98_7654_3210;
        start_a = 1'b1;
        wait_done(1000, cyc);
        chk("tie_resp", a_resp, 8'hF7);
        chk("tie_flag", a_tie, 1);
        chk("tie_to", a_to, 0);
        @(posedge clk); #1;

        // Timeout on race 5 (instance b, TIMEOUT=16)
        set_plan(7, 2'b01, 2'b01);
        plan_dly[5] = 0;
        challenge = 64'h1122_3344_5566_7788;
        start_b = 1'b1;
        wait_done(1000, cyc);
        chk("to_run_len", run_len[5], 16);
        chk("to_resp", b_resp, 8'hDF);
        chk("to_flag", b_to, 1);
        chk("to_tie", b_tie, 0);
        chk("to_later_raced", run_len[7], 7);
        @(posedge clk); #1;
        chk("to_b_busy", b_busy, 0);

        // Protocol: start while busy, flags outside RUN, changed challenge input
        set_plan(3, 2'b10, 2'b01);
        plan_val[0] = 2'b11;
        idle_fin = 2'b01;
        challenge = 64'h5A5A_C3C3_0F0F_9696;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        challenge = 64'hFFFF_FFFF_FFFF_FFFF;
        start_a = 1'b1;
        wait_done(1000, cyc);
        chk("prot_resp", a_resp, 8'hAA);
        chk("prot_tie", a_tie, 1);
        chk("prot_to", a_to, 0);

        // Back-to-back start in the cycle after done
        idle_fin = 2'b00;
        set_plan(2, 2'b01, 2'b01);
        challenge = 64'h0F1E_2D3C_4B5A_6978;
        @(posedge clk); #1;
        chk("b2b_done_once", a_done, 0);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("b2b_busy", a_busy, 1);
        chk("b2b_tie_clr", a_tie, 0);
        chk("b2b_resp_clr", a_resp, 0);
        wait_done(1000, cyc);
        chk("b2b_resp", a_resp, 8'hFF);
        chk("b2b_tie", a_tie, 0);
        @(posedge clk); #1;

        // Reset during RUN of bit 2
        set_plan(89, 2'b01, 2'b10);
        challenge = 64'h8899_AABB_CCDD_EEFF;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (!(race_idx == 2 && a_ro_en) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_reached_run2", (race_idx == 2 && a_ro_en), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_ro_en", a_ro_en, 0);
        chk("mid_busy", a_busy, 0);
        chk("mid_resp", a_resp, 0);
        chk("mid_cnt_rst", a_cnt_rst, 1);
        rst = 1'b0;
        dones = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (a_done) dones++;
        end
        chk("mid_no_done", dones, 0);
        chk("mid_idle", a_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ro_puf_ctrl.md
Name: ro_puf_ctrl

Overview:
- Sequencer for the ring-oscillator PUF race counter: per response bit, selects an RO pair, enables the oscillators, runs the race, captures the winner and shifts it into a response word.
- Sits between host logic (start/challenge/response handshake) and the RO mux plus the dual race counter.
- The race counter reports each finish as a 2-bit flag (one bit per side) and self-clears after any finish.

Parameters:
- RESP_BITS, 8, number of races (response bits) per challenge.
- SEL_W, 4, RO select width; supports 2^SEL_W oscillators.
- SETTLE, 4, idle cycles before and after each race; minimum 1.
- TIMEOUT, 4096, maximum RUN cycles before a race is aborted.
- TO_W, 13, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- challenge  in  RESP_BITS*2*SEL_W  pair list; race i uses sel_a = bits [2*SEL_W*i +: SEL_W] and sel_b = the next SEL_W bits.
- race_fin  in  2  race counter finish flags: [0] = side A reached goal, [1] = side B.
- sel_a  out  SEL_W  RO mux select, side A.
- sel_b  out  SEL_W  RO mux select, side B.
- ro_en  out  1  oscillator/count enable (gates both counter_in bits).
- cnt_rst  out  1  race counter reset.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; response valid from this cycle.
- response  out  RESP_BITS  bit i = result of race i.
- tie  out  1  sticky per challenge; some race had both flags set in the same cycle.
- timeout_err  out  1  sticky per challenge; some race aborted.

Behaviour:
- Reset: all outputs 0, cnt_rst = 1, state IDLE, bit index 0. Reset mid-operation aborts immediately with no done pulse.
- Challenge latch: latched on start acceptance. Later challenge changes have no effect until the next start.
- IDLE: cnt_rst = 1, ro_en = 0.
  - start=1: latch challenge; clear response, tie and timeout_err; index = 0; go to SETUP.
  - start while busy is ignored.
- SETUP: drive sel_a/sel_b for the current index, ro_en = 0, cnt_rst = 1 for SETTLE cycles, then go to RUN. Selects stay stable from SETUP through COOL.
- RUN: ro_en = 1, cnt_rst = 0, timeout counter increments each cycle. First cycle in which race_fin != 0:
  - 2'b01 -> bit = 1.
  - 2'b10 -> bit = 0.
  - 2'b11 -> bit = 0 and tie set.
  - In all three cases, ro_en drops in the next cycle.
  - If no finish within TIMEOUT RUN cycles: bit = 0, timeout_err set.
  - Any exit from RUN goes to CAPTURE.
- CAPTURE (1 cycle): response[index] <= bit, ro_en = 0, cnt_rst = 1.
- COOL: ro_en = 0, cnt_rst = 1 for SETTLE cycles.
  - If index == RESP_BITS-1, go to DONE.
  - Otherwise index + 1, go to SETUP.
- DONE (1 cycle): done = 1, busy = 0, go to IDLE. response, tie and timeout_err hold until the next accepted start.
- race_fin is ignored outside RUN. A flag asserted on the RUN entry cycle counts.
- sel_a == sel_b is not checked; it is raced as given and normally produces a tie or timeout.
- Latency per bit: SETTLE + race cycles + 1 + SETTLE. Total: RESP_BITS × that + 1 (DONE) + 1 (start acceptance).

Test Plan:
- Reset: hold rst 3 cycles -> busy=0, done=0, ro_en=0, cnt_rst=1, response=0.
- Nominal, RESP_BITS=8, SETTLE=4: model asserts race_fin=01 after 89 RUN cycles for even bits, 10 for odd bits -> response=8'h55, done pulses exactly once, tie=0, timeout_err=0. Check sel_a/sel_b match the challenge slices in each SETUP.
- Tie: race 3 returns 11 -> response[3]=0, tie=1, sequence completes normally.
- Timeout, TIMEOUT=16: race 5 never finishes -> ro_en drops after exactly 16 RUN cycles, response[5]=0, timeout_err=1, remaining bits still raced.
- Protocol: start pulsed while busy, and race_fin=01 forced during SETUP/COOL -> both ignored, result unchanged. Back-to-back start on the cycle after done -> accepted, flags cleared.
- Reset mid-race, in RUN of bit 2 -> next cycle ro_en=0, busy=0, response=0, no done pulse.
